// File: rtl/input_conditioner_pkg.sv
// Shared constants, sizing helper and event payload type for the input conditioner.
// The event payload is sized by WIDTH_DEF; the top rejects any other WIDTH at elaboration.
package input_conditioner_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int DB_CYCLES_DEF = 1024;
  localparam int GLITCH_CNT_W  = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef struct packed {
    logic [WIDTH_DEF-1:0] data;
    logic [WIDTH_DEF-1:0] rise;
    logic [WIDTH_DEF-1:0] fall;
  } evt_t;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One-bit two-flop synchroniser plus consecutive-cycle debounce counter and level flop.
// The glitch port exists only when INPUT_GLITCH_COUNT_EN is defined.
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic level_next
`ifdef INPUT_GLITCH_COUNT_EN
  ,
  output logic glitch
`endif
);

  localparam int CW = clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    level_next = level;
    cnt_next   = cnt;
    if (sync2 == level) begin
      cnt_next = '0;
    end else if (cnt == CNT_MAX) begin
      level_next = sync2;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

`ifdef INPUT_GLITCH_COUNT_EN
  // A mismatch that collapsed before reaching the threshold.
  assign glitch = (sync2 == level) && (cnt != '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      cnt   <= cnt_next;
      level <= level_next;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounced input front end: per-bit conditioning plus a change-event register with valid/ready.
// Define INPUT_GLITCH_COUNT_EN to build the saturating rejected-glitch counter.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        level,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [WIDTH-1:0]        evt_data,
  output logic [WIDTH-1:0]        evt_rise,
  output logic [WIDTH-1:0]        evt_fall,
  output logic                    overrun,
  input  logic                    ovf_clr,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("input_conditioner: DB_CYCLES must be >= 2");
  end
  if (WIDTH != WIDTH_DEF) begin : g_bad_width
    $error("input_conditioner: WIDTH must match the packaged event payload width");
  end

  logic [WIDTH-1:0] level_next;
`ifdef INPUT_GLITCH_COUNT_EN
  logic [WIDTH-1:0] glitch;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk        (clk),
      .rst        (rst),
      .din        (din[i]),
      .level      (level[i]),
      .level_next (level_next[i])
`ifdef INPUT_GLITCH_COUNT_EN
      ,
      .glitch     (glitch[i])
`endif
    );
  end

  logic             chg;
  logic             xfer;
  logic [WIDTH-1:0] rise_new;
  logic [WIDTH-1:0] fall_new;
  evt_t             evt_q;

  assign chg      = level_next != level;
  assign rise_new = level_next & ~level;
  assign fall_new = ~level_next & level;
  assign xfer     = evt_valid & evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_q     <= '0;
      overrun   <= 1'b0;
    end else if (chg && evt_valid && !xfer) begin
      // Consumer stalled: fold the new change into the pending event.
      evt_q.data <= level_next;
      evt_q.rise <= evt_q.rise | rise_new;
      evt_q.fall <= evt_q.fall | fall_new;
      overrun    <= 1'b1;
    end else begin
      if (ovf_clr) overrun <= 1'b0;
      if (chg) begin
        evt_q     <= '{data: level_next, rise: rise_new, fall: fall_new};
        evt_valid <= 1'b1;
      end else if (xfer) begin
        evt_valid <= 1'b0;
      end
    end
  end

  assign evt_data = evt_q.data;
  assign evt_rise = evt_q.rise;
  assign evt_fall = evt_q.fall;

`ifdef INPUT_GLITCH_COUNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_q <= '0;
    end else if ((|glitch) && (glitch_q != '1)) begin
      glitch_q <= glitch_q + 1'b1;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (WIDTH=8, DB_CYCLES=4): directed scenarios then random pins.
// A cycle-level reference model predicts levels and events; a monitor checks each transfer.
module tb_input_conditioner;

  localparam int W  = 8;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic [W-1:0] level;
  logic         evt_valid;
  logic         evt_ready;
  logic [W-1:0] evt_data;
  logic [W-1:0] evt_rise;
  logic [W-1:0] evt_fall;
  logic         overrun;
  logic         ovf_clr;
  logic [7:0]   glitch_cnt;

  input_conditioner #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .level      (level),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .evt_rise   (evt_rise),
    .evt_fall   (evt_fall),
    .overrun    (overrun),
    .ovf_clr    (ovf_clr),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pins reach the debouncer two edges late; a bit flips once
  // its synchronised value has disagreed with the level for DB consecutive edges.
  logic [W-1:0]  m_s1, m_s2, m_lvl, m_data, m_rise, m_fall;
  logic          m_valid, m_ovr;
  int            m_run [W];
  int            m_glc;
  logic [23:0]   sb_q [$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0;
    m_data = '0; m_rise = '0; m_fall = '0;
    m_valid = 1'b0; m_ovr = 1'b0; m_glc = 0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] nl, r, f;
    bit g, chg, xf;
    nl = m_lvl;
    g  = 0;
    for (int b = 0; b < W; b++) begin
      if (m_s2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          nl[b]    = m_s2[b];
          m_run[b] = 0;
        end
      end else begin
        if (m_run[b] != 0) g = 1;
        m_run[b] = 0;
      end
    end
    chg = (nl != m_lvl);
    r   = nl & ~m_lvl;
    f   = ~nl & m_lvl;
    xf  = m_valid && evt_ready;
    if (xf) sb_q.push_back({m_data, m_rise, m_fall});
    if (chg && m_valid && !xf) begin
      m_data = nl;
      m_rise = m_rise | r;
      m_fall = m_fall | f;
      m_ovr  = 1'b1;
    end else begin
      if (ovf_clr) m_ovr = 1'b0;
      if (chg) begin
        m_data  = nl;
        m_rise  = r;
        m_fall  = f;
        m_valid = 1'b1;
      end else if (xf) begin
        m_valid = 1'b0;
      end
    end
`ifdef INPUT_GLITCH_COUNT_EN
    if (g && m_glc < 255) m_glc++;
`endif
    m_lvl = nl;
    m_s2  = m_s1;
    m_s1  = din;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Continuous state comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("level", level, m_lvl);
      chk("evt_valid", evt_valid, m_valid);
      chk("evt_data", evt_data, m_data);
      chk("evt_rise", evt_rise, m_rise);
      chk("evt_fall", evt_fall, m_fall);
      chk("overrun", overrun, m_ovr);
      chk("glitch_cnt", glitch_cnt, m_glc);
    end
  end

  // Transfer monitor: capture the payload offered before the edge, compare after it.
  initial begin
    logic [23:0] got, exp;
    forever begin
      @(negedge clk);
      if (!rst && evt_valid && evt_ready) begin
        got = {evt_data, evt_rise, evt_fall};
        @(posedge clk);
        #1;
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
          exp = sb_q.pop_front();
          chk("xfer_payload", got, exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int glitch_exp;

  initial begin
`ifdef INPUT_GLITCH_COUNT_EN
    glitch_exp = 1;
`else
    glitch_exp = 0;
`endif
    rst = 1'b1; din = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Idle after reset
    tick(20);
    chk("idle_level", level, 8'h00);
    chk("idle_valid", evt_valid, 1'b0);
    chk("idle_data", {evt_data, evt_rise, evt_fall}, 24'h0);
    chk("idle_overrun", overrun, 1'b0);
    chk("idle_glitch", glitch_cnt, 8'h00);

    // Clean rise on bits 0 and 2
    evt_ready = 1'b1;
    din = 8'h05;
    tick(6);
    chk("rise_level", level, 8'h05);
    chk("rise_valid", evt_valid, 1'b1);
    chk("rise_mask", evt_rise, 8'h05);
    chk("rise_fall", evt_fall, 8'h00);
    tick(1);
    chk("rise_xfer_valid", evt_valid, 1'b0);

    // Two-cycle glitch on bit 3
    din = 8'h0D;
    tick(2);
    din = 8'h05;
    tick(10);
    chk("glitch_level", level, 8'h05);
    chk("glitch_valid", evt_valid, 1'b0);
    chk("glitch_count", glitch_cnt, glitch_exp);

    // Merge while stalled
    din = 8'h00;
    tick(10);
    evt_ready = 1'b0;
    din = 8'h01; tick(10);
    din = 8'h03; tick(10);
    din = 8'h02; tick(10);
    chk("merge_valid", evt_valid, 1'b1);
    chk("merge_data", evt_data, 8'h02);
    chk("merge_rise", evt_rise, 8'h03);
    chk("merge_fall", evt_fall, 8'h01);
    chk("merge_overrun", overrun, 1'b1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    chk("ovf_clear", overrun, 1'b0);
    evt_ready = 1'b1;
    tick(2);
    chk("merge_drained", evt_valid, 1'b0);

    // Transfer and new change on the same edge
    evt_ready = 1'b0;
    din = 8'h10;
    tick(10);
    chk("pre_same_edge_valid", evt_valid, 1'b1);
    din = 8'h30;
    tick(5);
    evt_ready = 1'b1;
    tick(1);
    chk("same_edge_valid", evt_valid, 1'b1);
    chk("same_edge_data", evt_data, 8'h30);
    chk("same_edge_rise", evt_rise, 8'h20);
    chk("same_edge_overrun", overrun, 1'b0);
    tick(2);

    // Asynchronous reset mid-debounce with an event pending
    evt_ready = 1'b0;
    din = 8'h00;
    tick(10);
    chk("pre_reset_valid", evt_valid, 1'b1);
    din = 8'h40;
    tick(4);
    #1 rst = 1'b1;
    #1;
    chk("reset_outputs", {level, evt_valid, evt_data, evt_rise, evt_fall, overrun},
        {8'h00, 1'b0, 24'h0, 1'b0});
    chk("reset_glitch", glitch_cnt, 8'h00);
    din = 8'hFF;
    tick(1);
    rst = 1'b0;
    tick(6);
    chk("post_reset_valid", evt_valid, 1'b1);
    chk("post_reset_rise", evt_rise, 8'hFF);
    chk("post_reset_data", evt_data, 8'hFF);
    evt_ready = 1'b1;
    tick(2);

    // Random pin activity, random backpressure and clears
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) din = din ^ 8'(1 << $urandom_range(0, 7));
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      tick(1);
    end

    ovf_clr = 1'b0;
    evt_ready = 1'b1;
    tick(20);
    chk("final_sb_empty", sb_q.size(), 0);
    chk("final_valid", evt_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
